chacha20_ks_xor: RTL and testbench

CHACHA20_KS_XOR -- requirements
Module: chacha20_ks_xor

---
 rtl/chacha20_ks_xor_pkg.sv | 32 +++
 rtl/chacha20_ks_xor_if.sv | 43 ++++
 rtl/chacha20_ks_xor.sv | 120 ++++++++++++
 tb/tb_chacha20_ks_xor.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_ks_xor_pkg.sv
// ---------------------------------------------------------------------------
// chacha20_pkg
// Shared types and constants for the ChaCha20 keystream XOR block.
//   state_t    : controller states (IDLE, FETCH, XOR, DONE)
//   BLK_BYTES  : bytes per keystream block (64)
//   BLK_W      : keystream block width in bits (512)
//   CNT_W      : block counter width (32)
//   DATA_W     : byte-stream width (8)
//   ks_byte()  : selects byte n of a block, byte n = blk[8n+7:8n]
// ---------------------------------------------------------------------------
package chacha20_pkg;

    localparam int BLK_BYTES = 64;
    localparam int BLK_W     = 512;
    localparam int CNT_W     = 32;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = $clog2(BLK_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_XOR   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // RFC 8439 serialisation: little-endian words, so byte n sits at bit 8n.
    function automatic logic [DATA_W-1:0] ks_byte(input logic [BLK_W-1:0] blk,
                                                  input logic [IDX_W-1:0] idx);
        return blk[{idx, 3'b000} +: DATA_W];
    endfunction

endpackage

// File: rtl/chacha20_ks_xor_if.sv
// ---------------------------------------------------------------------------
// chacha20_ks_xor_if
// Bundles the keystream-core handshake and the byte streams of
// chacha20_ks_xor.
//   ini                      : initial block counter for the next frame
//   ks_req / ks_cnt          : block request and its counter (to core)
//   ks_blk / ks_val          : keystream block and one-cycle strobe (from core)
//   dat_i/val_i/sof_i/eof_i  : input byte stream
//   cts_i                    : clear-to-send for the input stream
//   dat_o/val_o/sof_o/eof_o  : XORed output byte stream
//   don                      : one-cycle frame-complete pulse
// master = environment (core + stream source/sink), slave = chacha20_ks_xor.
// ---------------------------------------------------------------------------
interface chacha20_ks_xor_if;
    import chacha20_pkg::*;

    logic [CNT_W-1:0]  ini;
    logic              ks_req;
    logic [CNT_W-1:0]  ks_cnt;
    logic [BLK_W-1:0]  ks_blk;
    logic              ks_val;
    logic [DATA_W-1:0] dat_i;
    logic              val_i;
    logic              sof_i;
    logic              eof_i;
    logic              cts_i;
    logic [DATA_W-1:0] dat_o;
    logic              val_o;
    logic              sof_o;
    logic              eof_o;
    logic              don;

    modport master (
        output ini, ks_blk, ks_val, dat_i, val_i, sof_i, eof_i,
        input  ks_req, ks_cnt, cts_i, dat_o, val_o, sof_o, eof_o, don
    );

    modport slave (
        input  ini, ks_blk, ks_val, dat_i, val_i, sof_i, eof_i,
        output ks_req, ks_cnt, cts_i, dat_o, val_o, sof_o, eof_o, don
    );

endinterface

// File: rtl/chacha20_ks_xor.sv
// ---------------------------------------------------------------------------
// chacha20_ks_xor
// Frames a byte stream, requests 64-byte ChaCha20 keystream blocks from an
// external block core and XORs each byte with the matching keystream byte.
// Encrypts or decrypts (the operation is its own inverse).
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : chacha20_ks_xor_if.slave (core handshake, byte streams, don)
// Flow per frame: IDLE (load ini) -> FETCH (wait ks_val) -> XOR (64 bytes
// per block, refetch with cnt+1 after byte 63) -> DONE (don pulse) -> IDLE.
// ---------------------------------------------------------------------------
module chacha20_ks_xor
    import chacha20_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    chacha20_ks_xor_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_BYTES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              sof_wait;
    logic [BLK_W-1:0]  ks_reg;
    logic              ks_req_r;
    logic [CNT_W-1:0]  ks_cnt_r;

    logic [DATA_W-1:0] dat_p1;
    logic              vld_p1;
    logic              sof_p1;
    logic              eof_p1;
    logic              don_r;

    logic              take_p0;

    // Input stage: a byte is consumed only in XOR; while waiting for sof,
    // non-sof bytes are accepted (cts_i is high) but discarded.
    assign take_p0 = (state == ST_XOR) && bus.val_i && (!sof_wait || bus.sof_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sof_wait <= 1'b0;
            ks_reg   <= '0;
            ks_req_r <= 1'b0;
            ks_cnt_r <= '0;
            dat_p1   <= '0;
            vld_p1   <= 1'b0;
            sof_p1   <= 1'b0;
            eof_p1   <= 1'b0;
            don_r    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            sof_p1 <= 1'b0;
            eof_p1 <= 1'b0;
            don_r  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt      <= bus.ini;
                    idx      <= '0;
                    sof_wait <= 1'b1;
                    ks_req_r <= 1'b1;
                    ks_cnt_r <= bus.ini;
                    state    <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (bus.ks_val) begin
                        ks_reg   <= bus.ks_blk;
                        ks_req_r <= 1'b0;
                        state    <= ST_XOR;
                    end
                end

                ST_XOR: begin
                    // Output stage: one-cycle registered XOR result.
                    if (take_p0) begin
                        dat_p1   <= bus.dat_i ^ ks_byte(ks_reg, idx);
                        vld_p1   <= 1'b1;
                        sof_p1   <= sof_wait;
                        eof_p1   <= bus.eof_i;
                        sof_wait <= 1'b0;
                        idx      <= idx + IDX_W'(1);
                        // eof wins over the block-boundary refetch.
                        if (bus.eof_i) begin
                            state <= ST_DONE;
                        end else if (idx == IDX_LAST) begin
                            cnt      <= cnt + CNT_W'(1);
                            ks_cnt_r <= cnt + CNT_W'(1);
                            ks_req_r <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end

                ST_DONE: begin
                    don_r <= 1'b1;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cts_i  = (state == ST_XOR);
    assign bus.ks_req = ks_req_r;
    assign bus.ks_cnt = ks_cnt_r;
    assign bus.dat_o  = dat_p1;
    assign bus.val_o  = vld_p1;
    assign bus.sof_o  = sof_p1;
    assign bus.eof_o  = eof_p1;
    assign bus.don    = don_r;

endmodule

// File: tb/tb_chacha20_ks_xor.sv
// ---------------------------------------------------------------------------
// tb_chacha20_ks_xor
// Directed bench for chacha20_ks_xor. Contains an RFC 8439 block-function
// model acting as the external keystream core (key 00..1f, nonce
// 000000000000004a00000000), a stream driver and an output monitor.
// ---------------------------------------------------------------------------
module tb_chacha20_ks_xor;
    import chacha20_pkg::*;

    localparam int CORE_LAT = 2;
    localparam int WAIT_LIM = 400;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int errors = 0;
    int checks = 0;

    chacha20_ks_xor_if bus();

    chacha20_ks_xor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // logs filled by the core model and the monitor
    logic [31:0] req_log[$];
    logic [7:0]  out_dat[$];
    logic        out_sof[$];
    logic        out_eof[$];
    int          eof_cyc[$];
    int          don_cyc[$];
    logic [7:0]  fr[$];
    int          spur_cnt  = 0;
    int          spur_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] chacha_block(input logic [31:0] ctr);
        logic [31:0]  s[16];
        logic [31:0]  x[16];
        logic [511:0] blk;
        int qa, qb, qc, qd;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++)
            s[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        s[12] = ctr;
        s[13] = 32'h00000000;
        s[14] = 32'h4a000000;
        s[15] = 32'h00000000;
        for (int w = 0; w < 16; w++) x[w] = s[w];
        for (int rd = 0; rd < 10; rd++) begin
            for (int dg = 0; dg < 2; dg++) begin
                for (int i = 0; i < 4; i++) begin
                    qa = i;
                    qb = 4  + ((i + dg) % 4);
                    qc = 8  + ((i + 2*dg) % 4);
                    qd = 12 + ((i + 3*dg) % 4);
                    x[qa] = x[qa] + x[qb]; x[qd] = rotl(x[qd] ^ x[qa], 16);
                    x[qc] = x[qc] + x[qd]; x[qb] = rotl(x[qb] ^ x[qc], 12);
                    x[qa] = x[qa] + x[qb]; x[qd] = rotl(x[qd] ^ x[qa], 8);
                    x[qc] = x[qc] + x[qd]; x[qb] = rotl(x[qb] ^ x[qc], 7);
                end
            end
        end
        for (int w = 0; w < 16; w++) blk[32*w +: 32] = x[w] + s[w];
        return blk;
    endfunction

    // keystream core model: answers each request after CORE_LAT cycles
    initial begin
        logic [511:0] blk;
        bus.ks_val = 1'b0;
        bus.ks_blk = '0;
        forever begin
            @(negedge clk);
            if (spur_cnt != spur_done) begin
                bus.ks_blk = '1;
                bus.ks_val = 1'b1;
                @(negedge clk);
                bus.ks_val = 1'b0;
                bus.ks_blk = '0;
                spur_done++;
            end else if (rst === 1'b1 && bus.ks_req === 1'b1) begin
                req_log.push_back(bus.ks_cnt);
                blk = chacha_block(bus.ks_cnt);
                repeat (CORE_LAT) @(negedge clk);
                if (rst === 1'b1) begin
                    bus.ks_blk = blk;
                    bus.ks_val = 1'b1;
                end
                @(negedge clk);
                bus.ks_val = 1'b0;
            end
        end
    end

    // output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.val_o === 1'b1) begin
                out_dat.push_back(bus.dat_o);
                out_sof.push_back(bus.sof_o);
                out_eof.push_back(bus.eof_o);
                if (bus.eof_o === 1'b1) eof_cyc.push_back(cyc);
            end
            if (bus.don === 1'b1) don_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        req_log.delete(); out_dat.delete(); out_sof.delete(); out_eof.delete();
        eof_cyc.delete(); don_cyc.delete();
    endtask

    task automatic do_reset(input logic [31:0] ini_v);
        rst = 1'b0;
        bus.val_i = 1'b0;
        bus.ini = ini_v;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        bus.dat_i = d; bus.sof_i = s; bus.eof_i = e; bus.val_i = 1'b1;
        while (bus.cts_i !== 1'b1 && n < WAIT_LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIM) check("cts_wait", 32'(bus.cts_i), 32'd1);
        @(negedge clk);
        bus.val_i = 1'b0; bus.sof_i = 1'b0; bus.eof_i = 1'b0;
    endtask

    task automatic send_frame(input int sof2);
        for (int i = 0; i < fr.size(); i++)
            send_byte(fr[i], (i == 0) || (i == sof2), i == fr.size() - 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.don !== 1'b1 && n < WAIT_LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIM) check("don_wait", 32'(bus.don), 32'd1);
        check("don_no_req", 32'(bus.ks_req), 32'd0);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_cnt);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.ks_req !== 1'b1 && w < 2);
        check({tag, "_req"}, 32'(bus.ks_req), 32'd1);
        check({tag, "_cnt"}, bus.ks_cnt, exp_cnt);
    endtask

    // compares the captured frame against plaintext ^ model keystream
    task automatic compare_frame(input string tag, input logic [31:0] c0);
        logic [511:0] blk;
        logic [7:0]   exp;
        int nmis = 0, nflag = 0;
        check({tag, "_len"}, 32'(out_dat.size()), 32'(fr.size()));
        for (int i = 0; i < out_dat.size() && i < fr.size(); i++) begin
            if (i % 64 == 0) blk = chacha_block(c0 + 32'(i / 64));
            exp = fr[i] ^ blk[8*(i % 64) +: 8];
            if (out_dat[i] !== exp) nmis++;
            if (out_sof[i] !== (i == 0) || out_eof[i] !== (i == fr.size() - 1)) nflag++;
        end
        check({tag, "_data"}, 32'(nmis), 32'd0);
        check({tag, "_flags"}, 32'(nflag), 32'd0);
        check({tag, "_don_n"}, 32'(don_cyc.size()), 32'd1);
        if (don_cyc.size() > 0 && eof_cyc.size() > 0)
            check({tag, "_don_lat"}, 32'(don_cyc[0] - eof_cyc[0]), 32'd1);
        else
            check({tag, "_don_eof"}, 32'(eof_cyc.size()), 32'd1);
    endtask

    initial begin
        string pt;
        int    w;
        pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
        rst = 1'b0;
        bus.ini = 32'd1;
        bus.dat_i = '0; bus.val_i = 1'b0; bus.sof_i = 1'b0; bus.eof_i = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ks_req", 32'(bus.ks_req), 32'd0);
        check("rst_ks_cnt", bus.ks_cnt, 32'd0);
        check("rst_cts", 32'(bus.cts_i), 32'd0);
        check("rst_dat_o", 32'(bus.dat_o), 32'd0);
        check("rst_val_o", 32'(bus.val_o), 32'd0);
        check("rst_sof_o", 32'(bus.sof_o), 32'd0);
        check("rst_eof_o", 32'(bus.eof_o), 32'd0);
        check("rst_don", 32'(bus.don), 32'd0);
        rst = 1'b1;
        wait_req("rel", 32'd1);

        // RFC 8439 2.4.2 vector, ini = 1
        fr.delete();
        for (int i = 0; i < pt.len(); i++) fr.push_back(pt[i]);
        send_frame(-1);
        wait_done();
        if (out_dat.size() >= 114) begin
            check("rfc_c0", 32'(out_dat[0]), 32'h6e);
            check("rfc_c1", 32'(out_dat[1]), 32'h2e);
            check("rfc_c2", 32'(out_dat[2]), 32'h35);
            check("rfc_c3", 32'(out_dat[3]), 32'h9a);
            check("rfc_c112", 32'(out_dat[112]), 32'h87);
            check("rfc_c113", 32'(out_dat[113]), 32'h4d);
        end
        compare_frame("rfc", 32'd1);
        check("rfc_nreq", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("rfc_req0", req_log[0], 32'd1);
            check("rfc_req1", req_log[1], 32'd2);
        end

        // exact 64-byte frame: eof on idx 63 beats the refetch
        do_reset(32'd7);
        clear_logs();
        fr.delete();
        for (int i = 0; i < 64; i++) fr.push_back(8'(i * 3 + 1));
        send_frame(-1);
        wait_done();
        compare_frame("f64", 32'd7);
        check("f64_nreq", 32'(req_log.size()), 32'd1);
        if (req_log.size() >= 1) check("f64_req0", req_log[0], 32'd7);

        // counter wrap across a block boundary
        do_reset(32'hFFFFFFFF);
        clear_logs();
        fr.delete();
        for (int i = 0; i < 65; i++) fr.push_back(8'(8'hA5 ^ 8'(i)));
        send_frame(-1);
        wait_done();
        compare_frame("wrap", 32'hFFFFFFFF);
        check("wrap_nreq", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("wrap_req0", req_log[0], 32'hFFFFFFFF);
            check("wrap_req1", req_log[1], 32'h00000000);
        end

        // pre-sof bytes dropped, stray ks_val ignored, mid-frame sof ignored
        do_reset(32'd3);
        clear_logs();
        w = 0;
        while (bus.cts_i !== 1'b1 && w < WAIT_LIM) begin
            @(negedge clk);
            w++;
        end
        check("drop_cts", 32'(bus.cts_i), 32'd1);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("drop_no_out", 32'(out_dat.size()), 32'd0);
        spur_cnt++;
        repeat (3) @(negedge clk);
        check("spur_cts", 32'(bus.cts_i), 32'd1);
        fr.delete();
        for (int i = 0; i < 10; i++) fr.push_back(8'h00);
        send_frame(5);
        wait_done();
        compare_frame("zero", 32'd3);
        check("zero_nreq", 32'(req_log.size()), 32'd1);

        // reset at output byte 10 aborts the frame, restart with ini = 5
        do_reset(32'd9);
        clear_logs();
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'(8'h30 + i));
        for (int i = 0; i < 11; i++) send_byte(fr[i], i == 0, 1'b0);
        check("abort_nout", 32'(out_dat.size()), 32'd11);
        do_reset(32'd5);
        check("abort_val_o", 32'(bus.val_o), 32'd0);
        check("abort_eof", 32'(eof_cyc.size()), 32'd0);
        check("abort_don", 32'(don_cyc.size()), 32'd0);
        clear_logs();
        wait_req("new", 32'd5);
        fr.delete();
        for (int i = 0; i < 4; i++) fr.push_back(8'(8'h5A + i));
        send_frame(-1);
        wait_done();
        compare_frame("new", 32'd5);
        check("new_nreq", 32'(req_log.size()), 32'd1);
        if (req_log.size() >= 1) check("new_req0", req_log[0], 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
